// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: scans a stream of bytes, MSB first, for a 4-bit pattern and counts the matches.
// Latency: 1 LOAD cycle plus 8 SHIFT cycles per byte. match_pulse is registered and appears the
//   cycle after the matching bit. done appears the cycle after the last bit is consumed.
// Backpressure: byte_ready is high only in LOAD. A stall on byte_valid holds the FSM in LOAD.
// Ports:
//   clock, reset_n               clock and asynchronous active-low reset
//   start, cfg_pattern, cfg_overlap   start a scan; the config is latched when start is accepted
//   byte_valid/byte_data/byte_last    byte handshake, together with the output byte_ready
//   match_pulse, match_count          per-match pulse and saturating match count
//   busy, done                        FSM status
module seq_scan_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  input  logic             byte_last,
  output logic             byte_ready,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         pat_q, pat_d;
  logic               ovl_q, ovl_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               last_q, last_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [2:0]         hist_q, hist_d;
  logic [1:0]         hvld_q, hvld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mpulse_q, mpulse_d;
  logic               cur_bit;
  logic               match;

  // The bit under test is always the MSB of the shift register.
  assign cur_bit = shreg_q[7];
  assign match   = (state_q == SHIFT) && (hvld_q == 2'd3) &&
                   ({hist_q, cur_bit} == pat_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      ovl_q     <= 1'b0;
      shreg_q   <= '0;
      last_q    <= 1'b0;
      bit_idx_q <= '0;
      hist_q    <= '0;
      hvld_q    <= '0;
      cnt_q     <= '0;
      mpulse_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      ovl_q     <= ovl_d;
      shreg_q   <= shreg_d;
      last_q    <= last_d;
      bit_idx_q <= bit_idx_d;
      hist_q    <= hist_d;
      hvld_q    <= hvld_d;
      cnt_q     <= cnt_d;
      mpulse_q  <= mpulse_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    ovl_d     = ovl_q;
    shreg_d   = shreg_q;
    last_d    = last_q;
    bit_idx_d = bit_idx_q;
    hist_d    = hist_q;
    hvld_d    = hvld_q;
    cnt_d     = cnt_q;
    mpulse_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          pat_d   = cfg_pattern;
          ovl_d   = cfg_overlap;
          cnt_d   = '0;
          hist_d  = '0;
          hvld_d  = '0;
        end
      end
      LOAD: begin
        if (byte_valid) begin
          shreg_d   = byte_data;
          last_d    = byte_last;
          bit_idx_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d   = {shreg_q[6:0], 1'b0};
        hist_d    = {hist_q[1:0], cur_bit};
        bit_idx_d = bit_idx_q + 3'd1;
        if (match) begin
          mpulse_d = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
        // In non-overlapping mode a match consumes its bits. The history must then
        // refill with three fresh bits before another match can be declared.
        if (match && !ovl_q) begin
          hvld_d = 2'd0;
        end else if (hvld_q != 2'd3) begin
          hvld_d = hvld_q + 2'd1;
        end
        if (bit_idx_q == 3'd7) state_d = last_q ? DONE : LOAD;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // These outputs are decoded from registered state only.
  // Because of that, reset clears them immediately.
  assign byte_ready  = (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign match_pulse = mpulse_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed testbench for seq_scan_ctrl.
// Two instances share the same stimulus: CNT_W=8 for general checks, CNT_W=2 for saturation.
// Inputs are driven and outputs are sampled on the falling edge.
module tb_seq_scan_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_last;

  logic       byte_ready8, match_pulse8, busy8, done8;
  logic [7:0] match_count8;
  logic       byte_ready2, match_pulse2, busy2, done2;
  logic [1:0] match_count2;

  int vec  = 0;
  int miss = 0;

  always #5 clock = ~clock;

  seq_scan_ctrl #(.CNT_W(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready8), .match_pulse(match_pulse8),
    .match_count(match_count8), .busy(busy8), .done(done8)
  );

  seq_scan_ctrl #(.CNT_W(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready2), .match_pulse(match_pulse2),
    .match_count(match_count2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one scan of up to two bytes.
  // Cycle 0 is the cycle in which start is driven.
  // mask bit t is set when match_pulse (CNT_W=8) is high in cycle t.
  // n2 counts match pulses from the CNT_W=2 instance.
  // dcyc is the cycle in which done is seen, or -1 if done never appears.
  // Returns on the falling edge of the done cycle.
  task automatic scan(input logic [3:0] pat, input logic ovl,
                      input logic [7:0] b0, input logic [7:0] b1,
                      input int nb, input int stall,
                      output logic [31:0] mask, output int n2, output int dcyc);
    int idx;
    mask = '0; n2 = 0; dcyc = -1; idx = 0;
    @(negedge clock);
    start = 1'b1; cfg_pattern = pat; cfg_overlap = ovl;
    for (int t = 1; t < 60; t++) begin
      @(negedge clock);
      start = 1'b0;
      if (t == 1) chk("cnt_clr_on_start", match_count8, 0);
      if (match_pulse8) mask[t] = 1'b1;
      if (match_pulse2) n2++;
      byte_valid = 1'b0;
      if (t <= stall) begin
        chk("rdy_during_stall", byte_ready8, 1);
      end else if (byte_ready8 && idx < nb) begin
        byte_valid = 1'b1;
        byte_data  = (idx == 0) ? b0 : b1;
        byte_last  = (idx == nb - 1);
        idx++;
      end
      if (t >= stall + 2 && t <= stall + 9) chk("rdy_low_in_shift", byte_ready8, 0);
      if (done8) begin
        dcyc = t;
        break;
      end
    end
  endtask

  logic [31:0] mask;
  int          n2, dcyc;
  logic        saw_done, saw_busy;

  initial begin
    reset_n = 1'b0; start = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
    byte_valid = 1'b0; byte_data = '0; byte_last = 1'b0;

    // Reset state
    #12;
    chk("rst_ready", byte_ready8, 0);
    chk("rst_pulse", match_pulse8, 0);
    chk("rst_busy",  busy8, 0);
    chk("rst_done",  done8, 0);
    chk("rst_count", match_count8, 0);
    chk("rst_count2", match_count2, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Overlapping, pattern 0101, 0x55: matches after bits 4, 6 and 8
    scan(4'b0101, 1'b1, 8'h55, 8'h00, 1, 0, mask, n2, dcyc);
    chk("ovl_mask",  mask, 32'h0000_0540);
    chk("ovl_done",  dcyc, 10);
    chk("ovl_count", match_count8, 3);
    // A start driven in the DONE cycle must be ignored
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_in_done_busy", busy8, 0);
    chk("post_done_pulse", done8, 0);
    chk("count_hold_idle", match_count8, 3);
    @(negedge clock);
    chk("still_idle", busy8, 0);

    // Non-overlapping, 0x55: matches after bits 4 and 8
    scan(4'b0101, 1'b0, 8'h55, 8'h00, 1, 0, mask, n2, dcyc);
    chk("novl_mask",  mask, 32'h0000_0440);
    chk("novl_done",  dcyc, 10);
    chk("novl_count", match_count8, 2);

    // Match spanning the byte boundary: 0x01, 0x40, match at stream bit 10
    scan(4'b0101, 1'b1, 8'h01, 8'h40, 2, 0, mask, n2, dcyc);
    chk("span_mask",  mask, 32'h0000_2000);
    chk("span_done",  dcyc, 19);
    chk("span_count", match_count8, 1);

    // Three-cycle stall in LOAD delays everything by 3 cycles
    scan(4'b0101, 1'b1, 8'h55, 8'h00, 1, 3, mask, n2, dcyc);
    chk("stall_mask",  mask, 32'h0000_2A00);
    chk("stall_done",  dcyc, 13);
    chk("stall_count", match_count8, 3);

    // Two bytes of 0x55: 7 matches; the 2-bit counter saturates at 3
    scan(4'b0101, 1'b1, 8'h55, 8'h55, 2, 0, mask, n2, dcyc);
    chk("sat_mask",   mask, 32'h000A_A540);
    chk("sat_done",   dcyc, 19);
    chk("sat_pulses", n2, 7);
    chk("sat_count2", match_count2, 3);
    chk("sat_count8", match_count8, 7);

    // Reset asserted during the third SHIFT cycle
    @(negedge clock);
    start = 1'b1; cfg_pattern = 4'b0101; cfg_overlap = 1'b1;
    @(negedge clock);
    start = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h55; byte_last = 1'b1;
    @(negedge clock);
    byte_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("pre_rst_busy", busy8, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy",   busy8, 0);
    chk("mid_rst_ready",  byte_ready8, 0);
    chk("mid_rst_pulse",  match_pulse8, 0);
    chk("mid_rst_done",   done8, 0);
    chk("mid_rst_count",  match_count8, 0);
    @(negedge clock);
    reset_n = 1'b1;
    saw_done = 1'b0; saw_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      saw_done |= done8;
      saw_busy |= busy8;
    end
    chk("no_done_after_rst", saw_done, 0);
    chk("idle_after_rst",    saw_busy, 0);

    // A new start after the reset scans normally
    scan(4'b0101, 1'b0, 8'h55, 8'h00, 1, 0, mask, n2, dcyc);
    chk("recover_mask",  mask, 32'h0000_0440);
    chk("recover_count", match_count8, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, width of the match counter.
REQ-002 clock  input  1  single clock, all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begins a scan; sampled only in IDLE.
REQ-005 cfg_pattern  input  4  target pattern; bit 3 is the first-received bit. Latched on an accepted start.
REQ-006 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping. Latched on an accepted start.
REQ-007 byte_valid  input  1  requester presents byte_data and byte_last.
REQ-008 byte_data  input  8  byte to scan, shifted MSB first.
REQ-009 byte_last  input  1  marks the final byte of the scan.
REQ-010 byte_ready  output  1  controller accepts a byte this cycle.
REQ-011 match_pulse  output  1  one-cycle registered pulse per detected match.
REQ-012 match_count  output  CNT_W  matches in the current or last scan.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse at scan end.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, SHIFT and DONE.
REQ-016 IDLE, start=1 -> LOAD:
- latch cfg_pattern and cfg_overlap;
- clear match_count, bit history and history-valid count.
REQ-017 LOAD:
- byte_ready=1;
- on byte_valid&byte_ready: capture byte_data and byte_last, bit index=0, go to SHIFT;
- with byte_valid=0, stay in LOAD with no other change.
REQ-018 byte_ready SHALL be 0 in IDLE, SHIFT and DONE.
REQ-019 SHIFT SHALL consume exactly one bit per cycle for 8 cycles, MSB first.
REQ-020 After the 8th bit: byte_last=1 -> DONE; otherwise -> LOAD.
REQ-021 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-022 Match condition:
- history-valid count >= 3 and {3-bit history, current bit} == latched pattern;
- history-valid count saturates at 3;
- history and history-valid count persist across byte boundaries within a scan.
REQ-023 On a match at a SHIFT clock edge:
- match_count increments at that edge, saturating at 2^CNT_W-1;
- match_pulse is high for the following cycle.
REQ-024 On a match with overlap=0, history-valid SHALL clear to 0; with overlap=1, history SHALL shift normally.
REQ-025 match_count SHALL hold its value through DONE and IDLE until the next accepted start.
REQ-026 start SHALL be ignored outside IDLE, including during DONE.
REQ-027 Cycle timing:
- done is high exactly 1 cycle after the edge consuming the final bit;
- a scan of N bytes with no stalls takes 1 + 9N + 1 cycles from start to done.

Reset
REQ-028 reset_n=0 SHALL immediately force:
- state IDLE;
- byte_ready, match_pulse, busy, done = 0;
- match_count = 0;
- history, history-valid, bit index and shift register cleared.
REQ-029 Reset asserted mid-scan SHALL abort the scan with no done pulse; a new start is required after release.

Verification
REQ-030 overlap=1, pattern 0101, single byte 0x55 with last -> match_pulse after bits 4, 6 and 8; done with match_count=3.
REQ-031 overlap=0, pattern 0101, byte 0x55 with last -> matches after bits 4 and 8; match_count=2.
REQ-032 overlap=1, pattern 0101, bytes 0x01 then 0x40 (last) -> one match at stream bit 10, spanning the byte boundary; match_count=1.
REQ-033 byte_valid held low for 3 cycles in LOAD -> byte_ready stays 1, no shifting occurs, and done comes 3 cycles later than in the unstalled run.
REQ-034 reset_n pulsed low during the 3rd SHIFT cycle -> all outputs 0 asynchronously, no done; a start pulse while the FSM is in DONE is ignored.
REQ-035 CNT_W=2, overlap=1, pattern 0101, bytes 0x55, 0x55 (last) -> 7 match pulses, and match_count saturates at 3.
